div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle RV32M divide unit controller for the single-cycle core: DIV, DIVU, REM, REMU.
- Started by the decode stage when an OP_ALU instruction has funct7 = 0000001 and funct3[2] = 1.
- Stalls the core while it runs a radix-2 restoring divide, then presents the write-back result for one cycle.
- Owns its iteration counter, FSM, sign fix-up and RISC-V special-case handling.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- a  in  WIDTH  dividend (rs1), sampled with start
- b  in  WIDTH  divisor (rs2), sampled with start
- kill  in  1  synchronous abort (branch flush / trap)
- busy  out  1  operation in progress (any state but IDLE)
- stall  out  1  freeze PC/fetch; = (start & IDLE) | (busy & ~done)
- done  out  1  one-cycle pulse, result valid, write back rd
- result  out  WIDTH  quotient or remainder, held until next accepted start

Behaviour:
- Reset (reset = 0, async): state IDLE, busy 0, done 0, stall 0, result 0, counter 0, internal registers 0.
- FSM states: IDLE, SETUP, ITER, FIXUP, DONE.
- IDLE, start = 1 (cycle 0): latch op, a, b.
  - If b == 0 or signed overflow: go to DONE with the special result (done in cycle 1).
  - Otherwise go to SETUP.
- SETUP (cycle 1):
  - Signed ops (op[0] = 0): take magnitudes of a and b.
  - Record neg_q = a[MSB]^b[MSB] and neg_r = a[MSB].
  - Clear the remainder register and load the counter with WIDTH.
- ITER (cycles 2 .. WIDTH+1), one quotient bit per cycle:
  - Shift {rem, quo} left by 1 and trial-subtract the divisor (WIDTH+1-bit difference).
  - If non-negative: keep the difference and set the quotient LSB to 1; else restore.
  - Decrement the counter; move to FIXUP when it reaches 1.
- FIXUP (cycle WIDTH+2):
  - Signed ops: negate the quotient if neg_q, negate the remainder if neg_r.
  - Select the quotient (op[1] = 0) or the remainder (op[1] = 1) into result.
- DONE (cycle WIDTH+3): done = 1, stall = 0, next state IDLE.
- Latency:
  - Normal: start in cycle N → done in cycle N+WIDTH+3 (N+35 at WIDTH = 32).
  - Special case: done in cycle N+1.
- Special cases per RISC-V M:
  - b == 0: DIV/DIVU result all ones; REM/REMU result a.
  - Signed overflow (a = 100..0, b = all ones, op DIV/REM): DIV result a; REM result 0.
- start while busy: ignored; no queueing. The core cannot issue because stall is high.
- start in the DONE cycle: ignored. The core re-asserts start in the next cycle if needed.
- kill:
  - In any non-IDLE state: next state IDLE, no done pulse, result unchanged.
  - Has priority over the DONE transition.
  - kill & start in IDLE: start ignored.
- reset asserted mid-operation: immediate return to reset values. No done pulse after release.
- result changes only in FIXUP or on the special-case path into DONE.
- stall is combinational from state and start.
- All other outputs are registered.

Test Plan:
- DIV a=100, b=7: result 14, done exactly 35 cycles after start, stall high in cycles 0..34.
- REM a=-100 (0xFFFFFF9C), b=7: result 0xFFFFFFFE (-2). DIV with the same operands: result 0xFFFFFFF2 (-14).
- DIVU a=0xFFFFFFFF, b=2: result 0x7FFFFFFF. REMU with the same operands: result 1.
- Divide by zero, a=0x1234: DIVU result 0xFFFFFFFF, REM result 0x1234, done 1 cycle after start.
- Overflow, DIV a=0x80000000, b=0xFFFFFFFF: result 0x80000000. REM with the same operands: result 0. Both done in 1 cycle.
- Abort and reset:
  - Start DIV 100/7, kill in ITER cycle 10: busy 0 next cycle, no done, result keeps its prior value.
  - Start again, drive reset low at cycle 20: all outputs 0 asynchronously.
  - A new start after reset release completes normally.

Source files
------------

// File: rtl/div_sequencer.sv
// RV32M multi-cycle divide sequencer: radix-2 restoring divide for DIV/DIVU/REM/REMU.
// Holds the core via stall while iterating, then presents result with a one-cycle done pulse.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // state  | meaning
  // IDLE   | waiting for start
  // SETUP  | take operand magnitudes, record result signs, load counter
  // ITER   | one quotient bit per cycle, WIDTH cycles
  // FIXUP  | apply signs, select quotient or remainder into result
  // DONE   | done pulse, result valid for write-back
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, next_state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvs;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               neg_r;

  logic               accept;
  logic               div_zero;
  logic               overflow;
  logic               special;
  logic [WIDTH-1:0]   special_res;
  logic               signed_q;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;

  assign accept   = start & ~kill & (state == S_IDLE);
  assign div_zero = (b == '0);
  assign overflow = ~op[0] & (a == MIN_NEG) & (b == '1);
  assign special  = div_zero | overflow;
  assign signed_q = ~op_q[0];

  // Divide by zero and signed overflow follow the RISC-V M fixed results.
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op[1] ? a : '1;
    else          special_res = op[1] ? '0 : a;
  end

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = special ? S_DONE : S_SETUP;
      S_SETUP: next_state = S_ITER;
      S_ITER:  if (cnt == CNT_W'(1)) next_state = S_FIXUP;
      S_FIXUP: next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (kill && state != S_IDLE) next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state != S_IDLE);
      done <= (next_state == S_DONE);
    end
  end

  // quo/dvs hold the raw operands from start until SETUP converts them to magnitudes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= op;
            quo  <= a;
            dvs  <= b;
            if (special) result <= special_res;
          end
        end
        S_SETUP: begin
          quo   <= (signed_q && quo[WIDTH-1]) ? -quo : quo;
          dvs   <= (signed_q && dvs[WIDTH-1]) ? -dvs : dvs;
          neg_q <= signed_q & (quo[WIDTH-1] ^ dvs[WIDTH-1]);
          neg_r <= signed_q & quo[WIDTH-1];
          rem   <= '0;
          cnt   <= CNT_W'(WIDTH);
        end
        S_ITER: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
        end
        S_FIXUP: begin
          if (!kill) begin
            if (op_q[1]) result <= neg_r ? -rem : rem;
            else         result <= neg_q ? -quo : quo;
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational so the core freezes fetch in the same cycle it issues the divide.
  assign stall = (start && state == S_IDLE) ||
                 (state != S_IDLE && state != S_DONE);

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized scoreboard bench for div_sequencer: driver queues expected results and
// done cycles from an arithmetic reference model; a monitor checks each done pulse.
module tb_div_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         kill;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] result;

  div_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] res;
    int           at;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_res = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: RISC-V M semantics using native SV signed/unsigned arithmetic.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output bit special);
    int sx, sy;
    sx = x;
    sy = y;
    special = (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    case (o)
      2'b00: r = (y == 0) ? 32'hFFFF_FFFF : (special ? x : 32'(sx / sy));
      2'b01: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      2'b10: r = (y == 0) ? x : (special ? 32'h0 : 32'(sx % sy));
      default: r = (y == 0) ? x : x % y;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding, result=0x%08h cycle=%0d", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    bit           sp;
    bit           stall_bad;
    int           lat, n;
    model(o, x, y, r, sp);
    lat = sp ? 1 : W + 3;
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    n = cyc;
    sb.push_back('{res: r, at: n + lat});
    last_res  = r;
    stall_bad = 1'b0;
    for (int d = 0; d <= lat; d++) begin
      @(negedge clk);
      if (stall !== (d < lat)) stall_bad = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
    end
    check("stall_profile", 32'(stall_bad), 32'(0));
    check("idle_after_op", 32'(busy), 32'(0));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"},   32'(busy),  32'(0));
    check({name, "_done"},   32'(done),  32'(0));
    check({name, "_stall"},  32'(stall), 32'(0));
    check({name, "_result"}, result,     last_res);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    last_res = '0;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    run_op(2'b00, 32'd100, 32'd7);
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7);
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd2);
    run_op(2'b01, 32'h0000_1234, 32'd0);
    run_op(2'b10, 32'h0000_1234, 32'd0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // kill during ITER: no done, result keeps the previous value
    @(posedge clk); #1;
    op = 2'b00; a = 32'd100; b = 32'd7; start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < n + 10) begin
      @(posedge clk); #1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_kill");
    repeat (40) @(posedge clk);

    // kill together with start in IDLE: start ignored
    @(posedge clk); #1;
    op = 2'b00; a = 32'd50; b = 32'd5; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check_idle_outputs("kill_start");
    repeat (5) @(posedge clk);

    // async reset mid-operation
    @(posedge clk); #1;
    op = 2'b00; a = 32'd100; b = 32'd7; start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < n + 20) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b0;
    #1;
    last_res = '0;
    check_idle_outputs("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    run_op(2'b00, 32'd100, 32'd7);

    for (int i = 0; i < 150; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y;
      int           sel;
      o   = 2'($urandom);
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: y = '0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: y = -32'($urandom_range(1, 15));
        4: x = 32'($urandom_range(0, 20));
        default: ;
      endcase
      run_op(o, x, y);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
